// File: rtl/chr_band_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : chr_band_sequencer
//  Purpose  : Snoops the PPU fetch stream to track scanline and tile position.
//             Switches the CHR band at fixed scanline boundaries, so that each
//             horizontal band of the screen draws from its own CHR bank.
//             A double-buffer selector is latched only at vblank.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock, all state updates on rising edge
//    reset_n      in   asynchronous active-low reset
//    ppu_rd_n     in   PPU read strobe (synchronised)
//    ppu_addr     in   PPU address [13:0] (synchronised)
//    frame_start  in   one-cycle vblank pulse
//    buffer_sel   in   next buffer to display
//    buffer_req   in   one-cycle pulse posting buffer_sel
//    chr_addr     out  {cur_buffer, band, ppu_addr[11:0]}, zero-extended
//    band         out  current CHR band
//    scanline     out  current scanline count (saturating)
//    cur_buffer   out  buffer being displayed
//    frame_done   out  one-cycle pulse when all bands have been traversed
//    req_overrun  out  sticky: a posted request was overwritten
// ============================================================================
module chr_band_sequencer #(
    parameter int BANDS          = 4,
    parameter int LINES_PER_BAND = 64,
    parameter int SWITCH_TILE    = 40,
    parameter int FETCH_MATCH    = 4,
    parameter int BUF_BITS       = 1,
    parameter int ADDR_BITS      = 18
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ppu_rd_n,
    input  logic [13:0]                ppu_addr,
    input  logic                       frame_start,
    input  logic [BUF_BITS-1:0]        buffer_sel,
    input  logic                       buffer_req,
    output logic [ADDR_BITS-1:0]       chr_addr,
    output logic [$clog2(BANDS)-1:0]   band,
    output logic [7:0]                 scanline,
    output logic [BUF_BITS-1:0]        cur_buffer,
    output logic                       frame_done,
    output logic                       req_overrun
);

    localparam int c_BAND_BITS   = $clog2(BANDS);
    localparam int c_LPB_SHIFT   = $clog2(LINES_PER_BAND);
    localparam int c_FRAME_LINES = BANDS * LINES_PER_BAND;
    // The scanline counter saturates at 255, so a frame taller than that
    // completes when saturation is reached.
    localparam logic [7:0] c_DONE_LINE = (c_FRAME_LINES > 255) ? 8'd255 : 8'(c_FRAME_LINES);
    localparam logic [7:0] c_LPB_MASK  = 8'(LINES_PER_BAND - 1);
    localparam logic [2:0] c_MATCH_MAX = 3'(FETCH_MATCH - 1);
    localparam logic [5:0] c_TILE_MAX  = 6'd63;

    logic                   r_prev_rd_n;
    logic [2:0]             r_match;
    logic [7:0]             r_scanline;
    logic [5:0]             r_tile;
    logic [c_BAND_BITS-1:0] r_band;
    logic                   r_last_a13;
    logic                   r_frame_done;
    logic [BUF_BITS-1:0]    r_cur_buffer;
    logic [BUF_BITS-1:0]    r_pending;
    logic                   r_pend_valid;
    logic                   r_req_overrun;

    logic       w_fetch;
    logic       w_nt;
    logic       w_line_end;
    logic       w_tile_step;
    logic [7:0] w_scan_next;
    logic [7:0] w_band_idx;
    logic       w_on_boundary;
    logic       w_band_switch;

    // A fetch is the falling edge of the read strobe; the address is taken
    // in the same cycle the strobe is first seen low.
    assign w_fetch     = r_prev_rd_n & ~ppu_rd_n;
    assign w_nt        = (ppu_addr[13:12] == 2'b10);
    // A run of FETCH_MATCH back-to-back nametable fetches only happens at the
    // end-of-line garbage fetches, which marks the scanline boundary.
    assign w_line_end  = w_fetch & w_nt & (r_match == c_MATCH_MAX);
    // Each tile is one pattern-table access after nametable: an A13 fall.
    assign w_tile_step = w_fetch & r_last_a13 & ~ppu_addr[13];
    assign w_scan_next = (r_scanline == 8'hFF) ? 8'hFF : r_scanline + 8'd1;

    assign w_band_idx    = r_scanline >> c_LPB_SHIFT;
    assign w_on_boundary = ((r_scanline & c_LPB_MASK) == 8'd0) && (r_scanline != 8'd0);
    // Scanline only grows within a frame, so the band index is monotonic and
    // the BANDS bound stops it from ever wrapping.
    assign w_band_switch = w_fetch & ~r_last_a13 & ppu_addr[13]
                         & (r_tile == 6'(SWITCH_TILE))
                         & w_on_boundary
                         & (w_band_idx < 8'(BANDS));

    // Position tracking: frame_start wins over a fetch in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_rd_n  <= 1'b1;
            r_match      <= 3'd0;
            r_scanline   <= 8'd0;
            r_tile       <= 6'd0;
            r_band       <= '0;
            r_last_a13   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_prev_rd_n  <= ppu_rd_n;
            r_frame_done <= 1'b0;
            if (frame_start) begin
                r_match    <= 3'd0;
                r_scanline <= 8'd0;
                r_tile     <= 6'd0;
                r_band     <= '0;
                r_last_a13 <= 1'b0;
            end else if (w_fetch) begin
                r_last_a13 <= ppu_addr[13];
                if (!w_nt) begin
                    r_match <= 3'd0;
                end else if (r_match != c_MATCH_MAX) begin
                    r_match <= r_match + 3'd1;
                end
                if (w_line_end) begin
                    r_scanline <= w_scan_next;
                    r_tile     <= 6'd0;
                    if ((w_scan_next == c_DONE_LINE) && (r_scanline != c_DONE_LINE)) begin
                        r_frame_done <= 1'b1;
                    end
                end else if (w_tile_step && (r_tile != c_TILE_MAX)) begin
                    r_tile <= r_tile + 6'd1;
                end
                if (w_band_switch) begin
                    r_band <= w_band_idx[c_BAND_BITS-1:0];
                end
            end
        end
    end

    // Buffer selection: requests are held until vblank so the displayed
    // buffer never changes mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_buffer  <= '0;
            r_pending     <= '0;
            r_pend_valid  <= 1'b0;
            r_req_overrun <= 1'b0;
        end else begin
            if (frame_start) begin
                r_pend_valid <= 1'b0;
                if (buffer_req) begin
                    r_cur_buffer <= buffer_sel;
                end else if (r_pend_valid) begin
                    r_cur_buffer <= r_pending;
                end
            end else if (buffer_req) begin
                r_pending    <= buffer_sel;
                r_pend_valid <= 1'b1;
                if (r_pend_valid) begin
                    r_req_overrun <= 1'b1;
                end
            end
        end
    end

    assign chr_addr    = ADDR_BITS'({r_cur_buffer, r_band, ppu_addr[11:0]});
    assign band        = r_band;
    assign scanline    = r_scanline;
    assign cur_buffer  = r_cur_buffer;
    assign frame_done  = r_frame_done;
    assign req_overrun = r_req_overrun;

endmodule
`default_nettype wire

// File: tb/tb_chr_band_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chr_band_sequencer
//  Purpose  : Self-checking bench. Two instances share one stimulus stream:
//             u_dut_a uses default parameters, u_dut_b uses BANDS=8,
//             LINES_PER_BAND=32. Band steps and frame_done pulses are matched
//             against queued expectations by per-instance monitors; static
//             state is compared directly after each scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_chr_band_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ppu_rd_n;
    logic [13:0] ppu_addr;
    logic        frame_start;
    logic [0:0]  buffer_sel;
    logic        buffer_req;

    logic [17:0] chr_addr_a, chr_addr_b;
    logic [1:0]  band_a;
    logic [2:0]  band_b;
    logic [7:0]  scan_a, scan_b;
    logic [0:0]  cur_a, cur_b;
    logic        done_a, done_b;
    logic        ovr_a, ovr_b;

    always #5 clk = ~clk;

    chr_band_sequencer u_dut_a (
        .clk(clk), .reset_n(reset_n), .ppu_rd_n(ppu_rd_n), .ppu_addr(ppu_addr),
        .frame_start(frame_start), .buffer_sel(buffer_sel), .buffer_req(buffer_req),
        .chr_addr(chr_addr_a), .band(band_a), .scanline(scan_a), .cur_buffer(cur_a),
        .frame_done(done_a), .req_overrun(ovr_a)
    );

    chr_band_sequencer #(.BANDS(8), .LINES_PER_BAND(32)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .ppu_rd_n(ppu_rd_n), .ppu_addr(ppu_addr),
        .frame_start(frame_start), .buffer_sel(buffer_sel), .buffer_req(buffer_req),
        .chr_addr(chr_addr_b), .band(band_b), .scanline(scan_b), .cur_buffer(cur_b),
        .frame_done(done_b), .req_overrun(ovr_b)
    );

    typedef struct {
        int scan;
        int band;
    } band_ev_t;

    band_ev_t band_q_a[$];
    band_ev_t band_q_b[$];
    int       done_q_a[$];
    int       done_q_b[$];

    int tests = 0;
    int fails = 0;
    int prev_band_a = 0;
    int prev_band_b = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (int'(band_a) > prev_band_a) begin
            if (band_q_a.size() == 0) begin
                check("band_a_unexpected_step", int'(band_a), prev_band_a);
            end else begin
                band_ev_t ev;
                ev = band_q_a.pop_front();
                check("band_a_step", int'(band_a), ev.band);
                check("band_a_step_scanline", int'(scan_a), ev.scan);
            end
        end
        prev_band_a = int'(band_a);
        if (done_a) begin
            if (done_q_a.size() == 0) check("frame_done_a_unexpected", 1, 0);
            else check("frame_done_a_scanline", int'(scan_a), done_q_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (int'(band_b) > prev_band_b) begin
            if (band_q_b.size() == 0) begin
                check("band_b_unexpected_step", int'(band_b), prev_band_b);
            end else begin
                band_ev_t ev;
                ev = band_q_b.pop_front();
                check("band_b_step", int'(band_b), ev.band);
                check("band_b_step_scanline", int'(scan_b), ev.scan);
            end
        end
        prev_band_b = int'(band_b);
        if (done_b) begin
            if (done_q_b.size() == 0) check("frame_done_b_unexpected", 1, 0);
            else check("frame_done_b_scanline", int'(scan_b), done_q_b.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [13:0] a);
        ppu_rd_n = 1'b0;
        ppu_addr = a;
        tick();
        ppu_rd_n = 1'b1;
        tick();
    endtask

    // 4 NT fetches end the line; optional 40 pattern/NT tile pairs; a final
    // pattern fetch breaks the NT run so the next line counts cleanly.
    task automatic line(input bit tiles);
        repeat (4) fetch(14'h2000);
        if (tiles) begin
            for (int t = 0; t < 40; t++) begin
                fetch(14'h0010 + 14'(t));
                fetch(14'h2001 + 14'(t));
            end
        end
        fetch(14'h0FF0);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic post_req(input logic sel);
        buffer_sel = sel;
        buffer_req = 1'b1;
        tick();
        buffer_req = 1'b0;
    endtask

    task automatic push_band(input bit dut_b, input int s, input int b);
        band_ev_t ev;
        ev.scan = s;
        ev.band = b;
        if (dut_b) band_q_b.push_back(ev);
        else band_q_a.push_back(ev);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n     = 1'b0;
        ppu_rd_n    = 1'b1;
        ppu_addr    = 14'h0000;
        frame_start = 1'b0;
        buffer_sel  = 1'b0;
        buffer_req  = 1'b0;
        repeat (3) tick();

        check("reset_scanline_a", int'(scan_a), 0);
        check("reset_band_a", int'(band_a), 0);
        check("reset_cur_a", int'(cur_a), 0);
        check("reset_done_a", int'(done_a), 0);
        check("reset_overrun_a", int'(ovr_a), 0);
        check("reset_chr_addr_b", int'(chr_addr_b), 0);
        reset_n = 1'b1;
        tick();

        // Full frame, default and 8-band instances; mid-frame buffer post.
        push_band(0, 64, 1);  push_band(0, 128, 2); push_band(0, 192, 3);
        for (int i = 1; i < 8; i++) push_band(1, 32 * i, i);
        done_q_a.push_back(255);
        done_q_b.push_back(255);
        pulse_fs();
        for (int l = 1; l <= 256; l++) begin
            line(1'b1);
            if (l == 10) post_req(1'b1);
        end
        check("full_scanline_a", int'(scan_a), 255);
        check("full_scanline_b", int'(scan_b), 255);
        check("full_band_a", int'(band_a), 3);
        check("full_band_b", int'(band_b), 7);
        check("midframe_cur_held_a", int'(cur_a), 0);
        check("full_overrun_a", int'(ovr_a), 0);
        ppu_addr = 14'h0ABC;
        tick();
        check("chr_addr_a_pre", int'(chr_addr_a), 32'h3ABC);
        check("chr_addr_b_pre", int'(chr_addr_b), 32'h7ABC);
        pulse_fs();
        check("fs_cur_a", int'(cur_a), 1);
        check("fs_cur_b", int'(cur_b), 1);
        check("fs_scanline_a", int'(scan_a), 0);
        check("fs_band_a", int'(band_a), 0);
        check("fs_band_b", int'(band_b), 0);
        check("chr_addr_a_post", int'(chr_addr_a), 32'h4ABC);
        check("chr_addr_b_post", int'(chr_addr_b), 32'h8ABC);

        // Request coincident with frame_start overrides a pending one.
        post_req(1'b1);
        check("single_req_no_overrun", int'(ovr_a), 0);
        buffer_sel  = 1'b0;
        buffer_req  = 1'b1;
        frame_start = 1'b1;
        tick();
        buffer_req  = 1'b0;
        frame_start = 1'b0;
        check("coincident_cur_a", int'(cur_a), 0);
        check("coincident_overrun_a", int'(ovr_a), 0);
        pulse_fs();
        check("coincident_pend_cleared", int'(cur_a), 0);
        // Two posts in one frame overwrite the first.
        post_req(1'b1);
        check("first_post_no_overrun", int'(ovr_b), 0);
        post_req(1'b0);
        check("double_post_overrun_a", int'(ovr_a), 1);
        check("double_post_cur_held", int'(cur_a), 0);
        pulse_fs();
        check("double_post_cur_after_fs", int'(cur_a), 0);
        check("overrun_sticky_a", int'(ovr_a), 1);

        // frame_start coincident with a fetch at scanline 100.
        push_band(0, 64, 1);
        push_band(1, 64, 2);
        pulse_fs();
        for (int l = 1; l <= 100; l++) line(l == 64);
        check("s100_scanline_a", int'(scan_a), 100);
        check("s100_scanline_b", int'(scan_b), 100);
        repeat (3) fetch(14'h2000);
        frame_start = 1'b1;
        ppu_rd_n    = 1'b0;
        ppu_addr    = 14'h2000;
        tick();
        frame_start = 1'b0;
        ppu_rd_n    = 1'b1;
        tick();
        check("fs_fetch_scanline_a", int'(scan_a), 0);
        check("fs_fetch_band_a", int'(band_a), 0);
        check("fs_fetch_band_b", int'(band_b), 0);
        repeat (3) fetch(14'h2000);
        check("fs_fetch_discarded", int'(scan_a), 0);
        fetch(14'h2000);
        check("fs_fetch_resume", int'(scan_a), 1);

        // Three NT fetches per line never mark a scanline.
        pulse_fs();
        repeat (20) begin
            repeat (3) fetch(14'h2000);
            fetch(14'h0100);
        end
        check("three_nt_scanline_a", int'(scan_a), 0);

        // Asynchronous reset at scanline 130 with pending request.
        post_req(1'b1);
        pulse_fs();
        push_band(0, 128, 2);
        push_band(1, 128, 4);
        for (int l = 1; l <= 130; l++) line(l == 128);
        post_req(1'b1);
        ppu_addr = 14'h0000;
        tick();
        check("pre_reset_scanline_a", int'(scan_a), 130);
        check("pre_reset_band_a", int'(band_a), 2);
        check("pre_reset_cur_a", int'(cur_a), 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_scanline_a", int'(scan_a), 0);
        check("async_band_a", int'(band_a), 0);
        check("async_band_b", int'(band_b), 0);
        check("async_cur_a", int'(cur_a), 0);
        check("async_overrun_a", int'(ovr_a), 0);
        check("async_done_a", int'(done_a), 0);
        check("async_chr_addr_a", int'(chr_addr_a), 0);
        check("async_chr_addr_b", int'(chr_addr_b), 0);
        tick();
        reset_n = 1'b1;
        tick();
        pulse_fs();
        check("reset_discards_pending", int'(cur_a), 0);
        repeat (4) fetch(14'h2000);
        check("post_reset_count_a", int'(scan_a), 1);
        check("post_reset_count_b", int'(scan_b), 1);

        repeat (2) tick();
        check("band_q_a_empty", band_q_a.size(), 0);
        check("band_q_b_empty", band_q_b.size(), 0);
        check("done_q_a_empty", done_q_a.size(), 0);
        check("done_q_b_empty", done_q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
